// File: rtl/instr_fetch_seq.sv
// Instruction fetch sequencer: reads one or two instruction words starting at a PC
// and writes them into IR1/IR2 of the register file, then reports the advanced PC.

package common_pkg;
  localparam logic [3:0] R_IR1 = 4'd1;
  localparam logic [3:0] R_IR2 = 4'd2;
endpackage

module instr_fetch_seq #(
  parameter logic [3:0]  IR1_ADDR = common_pkg::R_IR1,
  parameter logic [3:0]  IR2_ADDR = common_pkg::R_IR2,
  parameter int unsigned LONG_BIT = 15
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic        i_flush,
  input  logic [15:0] i_pc,
  output logic        o_mem_req,
  output logic [15:0] o_mem_addr,
  input  logic        i_mem_ack,
  input  logic [15:0] i_mem_rdata,
  output logic        o_wr_en,
  output logic [3:0]  o_dest_addr,
  output logic [15:0] o_dest_data,
  output logic [15:0] o_pc_next,
  output logic        o_busy,
  output logic        o_done
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH1 = 3'd1;
  localparam logic [2:0] S_WR1    = 3'd2;
  localparam logic [2:0] S_FETCH2 = 3'd3;
  localparam logic [2:0] S_WR2    = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  logic [2:0]  state;
  logic [2:0]  state_nx;
  logic [15:0] pc;
  logic [15:0] word0;
  logic [15:0] word1;
  logic [15:0] pc_next_q;
  logic        is_long;

  assign is_long = word0[LONG_BIT];

  // Flush overrides every other input and always returns to IDLE.
  always_comb begin
    state_nx = state;
    if (i_flush) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE:   if (i_start)   state_nx = S_FETCH1;
        S_FETCH1: if (i_mem_ack) state_nx = S_WR1;
        S_WR1:    state_nx = is_long ? S_FETCH2 : S_DONE;
        S_FETCH2: if (i_mem_ack) state_nx = S_WR2;
        S_WR2:    state_nx = S_DONE;
        S_DONE:   state_nx = S_IDLE;
        default:  state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state     <= S_IDLE;
      pc        <= '0;
      word0     <= '0;
      word1     <= '0;
      pc_next_q <= '0;
    end else begin
      state <= state_nx;
      if (!i_flush) begin
        if (state == S_IDLE && i_start)
          pc <= i_pc;
        if (state == S_FETCH1 && i_mem_ack)
          word0 <= i_mem_rdata;
        if (state == S_FETCH2 && i_mem_ack)
          word1 <= i_mem_rdata;
        if (state == S_WR1 && !is_long)
          pc_next_q <= pc + 16'd1;
        if (state == S_WR2)
          pc_next_q <= pc + 16'd2;
      end
    end
  end

  always_comb begin
    o_mem_req   = 1'b0;
    o_mem_addr  = '0;
    o_wr_en     = 1'b0;
    o_dest_addr = '0;
    o_dest_data = '0;
    o_done      = 1'b0;
    if (!i_flush) begin
      case (state)
        S_FETCH1: begin
          o_mem_req  = 1'b1;
          o_mem_addr = pc;
        end
        S_FETCH2: begin
          o_mem_req  = 1'b1;
          o_mem_addr = pc + 16'd1;
        end
        S_WR1: begin
          o_wr_en     = 1'b1;
          o_dest_addr = IR1_ADDR;
          o_dest_data = word0;
        end
        S_WR2: begin
          o_wr_en     = 1'b1;
          o_dest_addr = IR2_ADDR;
          o_dest_data = word1;
        end
        S_DONE:  o_done = 1'b1;
        default: ;
      endcase
    end
  end

  assign o_busy    = (state != S_IDLE);
  assign o_pc_next = pc_next_q;

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Self-checking bench for instr_fetch_seq: word-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.

module tb_instr_fetch_seq;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_start = 1'b0;
  logic        i_flush = 1'b0;
  logic [15:0] i_pc = '0;
  logic        o_mem_req;
  logic [15:0] o_mem_addr;
  logic        i_mem_ack = 1'b0;
  logic [15:0] i_mem_rdata = '0;
  logic        o_wr_en;
  logic [3:0]  o_dest_addr;
  logic [15:0] o_dest_data;
  logic [15:0] o_pc_next;
  logic        o_busy;
  logic        o_done;

  localparam logic [3:0] IR1 = common_pkg::R_IR1;
  localparam logic [3:0] IR2 = common_pkg::R_IR2;

  instr_fetch_seq #(.LONG_BIT(15)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_flush(i_flush),
    .i_pc(i_pc), .o_mem_req(o_mem_req), .o_mem_addr(o_mem_addr),
    .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata), .o_wr_en(o_wr_en),
    .o_dest_addr(o_dest_addr), .o_dest_data(o_dest_data), .o_pc_next(o_pc_next),
    .o_busy(o_busy), .o_done(o_done)
  );

  always #5 i_clk = ~i_clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: a fetch is a sequence of (read word k, write word k) steps,
  // followed by one finishing cycle. phase: 0 none, 1 reading, 2 writing, 3 finishing.
  int          m_phase = 0;
  int          m_idx = 0;
  logic [15:0] m_pc = '0;
  logic [15:0] m_word [2] = '{16'h0, 16'h0};
  logic [15:0] m_pcnext = '0;
  bit          check_en = 0;

  always @(posedge i_clk) begin
    if (!i_rst_n) begin
      m_phase  = 0;
      m_idx    = 0;
      m_pc     = '0;
      m_word   = '{16'h0, 16'h0};
      m_pcnext = '0;
    end else if (i_flush) begin
      m_phase = 0;
    end else begin
      case (m_phase)
        0: if (i_start) begin m_pc = i_pc; m_idx = 0; m_phase = 1; end
        1: if (i_mem_ack) begin m_word[m_idx] = i_mem_rdata; m_phase = 2; end
        2: if (m_idx == 0 && m_word[0][15]) begin
             m_idx = 1; m_phase = 1;
           end else begin
             m_pcnext = m_pc + 16'(m_idx) + 16'd1;
             m_phase  = 3;
           end
        default: m_phase = 0;
      endcase
    end
  end

  int          n_wr = 0;
  int          n_done = 0;
  logic [3:0]  last_dest = '0;
  logic [15:0] last_data = '0;
  logic [15:0] last_req_addr = '0;

  always @(negedge i_clk) begin
    logic        e_req, e_wr;
    logic [15:0] e_addr, e_data;
    logic [3:0]  e_dest;
    if (check_en) begin
      e_req  = (m_phase == 1) && !i_flush;
      e_addr = e_req ? m_pc + 16'(m_idx) : 16'h0;
      e_wr   = (m_phase == 2) && !i_flush;
      e_dest = e_wr ? ((m_idx == 1) ? IR2 : IR1) : 4'h0;
      e_data = e_wr ? m_word[m_idx] : 16'h0;
      chk("mem_req",   {15'b0, o_mem_req},   {15'b0, e_req});
      chk("mem_addr",  o_mem_addr,           e_addr);
      chk("wr_en",     {15'b0, o_wr_en},     {15'b0, e_wr});
      chk("dest_addr", {12'b0, o_dest_addr}, {12'b0, e_dest});
      chk("dest_data", o_dest_data,          e_data);
      chk("busy",      {15'b0, o_busy},      {15'b0, 1'(m_phase != 0)});
      chk("done",      {15'b0, o_done},      {15'b0, 1'((m_phase == 3) && !i_flush)});
      chk("pc_next",   o_pc_next,            m_pcnext);
    end
    if (o_wr_en === 1'b1) begin n_wr++; last_dest = o_dest_addr; last_data = o_dest_data; end
    if (o_done === 1'b1) n_done++;
    if (o_mem_req === 1'b1) last_req_addr = o_mem_addr;
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Drives one complete fetch, acking each read after 'waits' idle request cycles.
  task automatic do_fetch(input logic [15:0] pc, input logic [15:0] w0, input logic [15:0] w1,
                          input int waits);
    int guard;
    i_pc = pc; i_start = 1'b1;
    step();
    i_start = 1'b0;
    for (int w = 0; w < 2; w++) begin
      if (w == 1 && !w0[15]) break;
      guard = 0;
      while (o_mem_req !== 1'b1 && guard < 10) begin step(); guard++; end
      if (guard >= 10) begin tests++; fails++; $display("FAIL req_timeout word %0d", w); end
      for (int k = 0; k < waits; k++) step();
      i_mem_ack = 1'b1; i_mem_rdata = (w == 1) ? w1 : w0;
      step();
      i_mem_ack = 1'b0; i_mem_rdata = 16'($urandom);
    end
    guard = 0;
    while (o_done !== 1'b1 && guard < 10) begin step(); guard++; end
    if (guard >= 10) begin tests++; fails++; $display("FAIL done_timeout pc %h", pc); end
    step();
  endtask

  initial begin
    int w0, d0;
    // Reset
    i_rst_n = 1'b0;
    step(); step();
    i_rst_n = 1'b1;
    check_en = 1;
    chk("rst_busy", {15'b0, o_busy}, 16'h0);
    chk("rst_pc_next", o_pc_next, 16'h0);
    chk("rst_req", {15'b0, o_mem_req}, 16'h0);

    // 1 short fetch, zero wait
    w0 = n_wr; d0 = n_done;
    do_fetch(16'h0100, 16'h1234, 16'h0, 0);
    chk("t1_writes", 16'(n_wr - w0), 16'd1);
    chk("t1_dest", {12'b0, last_dest}, {12'b0, IR1});
    chk("t1_data", last_data, 16'h1234);
    chk("t1_pc_next", o_pc_next, 16'h0101);
    chk("t1_model_pc_next", m_pcnext, 16'h0101);
    chk("t1_done", 16'(n_done - d0), 16'd1);

    // 2 long fetch with 3 wait cycles per read
    w0 = n_wr;
    do_fetch(16'h0100, 16'h8001, 16'hBEEF, 3);
    chk("t2_writes", 16'(n_wr - w0), 16'd2);
    chk("t2_dest", {12'b0, last_dest}, {12'b0, IR2});
    chk("t2_data", last_data, 16'hBEEF);
    chk("t2_req_addr", last_req_addr, 16'h0101);
    chk("t2_pc_next", o_pc_next, 16'h0102);
    chk("t2_model_pc_next", m_pcnext, 16'h0102);

    // 3 address wrap
    do_fetch(16'hFFFF, 16'hC000, 16'h5A5A, 0);
    chk("t3_req_addr", last_req_addr, 16'h0000);
    chk("t3_pc_next", o_pc_next, 16'h0001);

    // 4a flush during WR1
    w0 = n_wr; d0 = n_done;
    i_pc = 16'h0200; i_start = 1'b1; step(); i_start = 1'b0;
    i_mem_ack = 1'b1; i_mem_rdata = 16'h0003; step(); i_mem_ack = 1'b0;
    i_flush = 1'b1; step(); i_flush = 1'b0;
    chk("t4a_busy", {15'b0, o_busy}, 16'h0);
    step(); step();
    chk("t4a_writes", 16'(n_wr - w0), 16'd0);
    chk("t4a_done", 16'(n_done - d0), 16'd0);
    chk("t4a_pc_next", o_pc_next, 16'h0001);
    do_fetch(16'h0300, 16'h1111, 16'h0, 1);
    chk("t4a_restart_pc_next", o_pc_next, 16'h0301);

    // 4b flush together with ack in FETCH2
    w0 = n_wr; d0 = n_done;
    i_pc = 16'h0400; i_start = 1'b1; step(); i_start = 1'b0;
    i_mem_ack = 1'b1; i_mem_rdata = 16'h8000; step(); i_mem_ack = 1'b0;
    step();
    i_mem_ack = 1'b1; i_flush = 1'b1; i_mem_rdata = 16'h2222; step();
    i_mem_ack = 1'b0; i_flush = 1'b0;
    chk("t4b_busy", {15'b0, o_busy}, 16'h0);
    step(); step();
    chk("t4b_writes", 16'(n_wr - w0), 16'd1);
    chk("t4b_done", 16'(n_done - d0), 16'd0);
    chk("t4b_pc_next", o_pc_next, 16'h0301);

    // 5 reset in FETCH2, then stray acks
    w0 = n_wr;
    i_pc = 16'h0500; i_start = 1'b1; step(); i_start = 1'b0;
    i_mem_ack = 1'b1; i_mem_rdata = 16'h8000; step(); i_mem_ack = 1'b0;
    step();
    i_rst_n = 1'b0; step(); i_rst_n = 1'b1;
    chk("t5_busy", {15'b0, o_busy}, 16'h0);
    chk("t5_pc_next", o_pc_next, 16'h0);
    i_mem_ack = 1'b1; step(); step(); i_mem_ack = 1'b0;
    chk("t5_writes", 16'(n_wr - w0), 16'd1);
    chk("t5_busy_after", {15'b0, o_busy}, 16'h0);

    // 6 i_start held with memory always acking: one fetch per IDLE entry
    w0 = n_wr; d0 = n_done;
    i_pc = 16'h0600; i_start = 1'b1; i_mem_ack = 1'b1; i_mem_rdata = 16'h0007;
    for (int c = 0; c < 8; c++) step();
    i_start = 1'b0;
    for (int c = 0; c < 3; c++) step();
    i_mem_ack = 1'b0;
    chk("t6_writes", 16'(n_wr - w0), 16'd2);
    chk("t6_done", 16'(n_done - d0), 16'd2);
    chk("t6_pc_next", o_pc_next, 16'h0601);

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      i_rst_n     = ($urandom_range(0, 199) != 0);
      i_start     = ($urandom_range(0, 4) == 0);
      i_flush     = ($urandom_range(0, 24) == 0);
      i_mem_ack   = ($urandom_range(0, 2) == 0);
      i_mem_rdata = 16'($urandom);
      i_pc        = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      step();
    end
    i_rst_n = 1'b1; i_start = 1'b0; i_flush = 1'b0; i_mem_ack = 1'b0;
    step(); step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
